fifo_read_ctrl: RTL



---
 rtl/fifo_rd_pkg.sv | 16 +
 rtl/fifo_read_ctrl_if.sv | 27 ++
 rtl/rd_skid_buf.sv | 56 +++++
 rtl/fifo_read_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side drain controller.
package fifo_rd_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_state_t;

  localparam int CNT_W = 16;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// FIFO-facing and stream-facing signals of the read controller.
// The master modport is the controller; the slave modport is its environment.
interface fifo_read_ctrl_if #(
  parameter int WIDTH = 16
);

  logic                           fifo_rempty;
  logic                           fifo_rinc;
  logic [WIDTH-1:0]               fifo_rdata;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               out_data;
  logic                           flush;
  logic                           flush_busy;
  logic [fifo_rd_pkg::CNT_W-1:0]  out_cnt;

  modport master (
    input  fifo_rempty, fifo_rdata, out_ready, flush,
    output fifo_rinc, out_valid, out_data, flush_busy, out_cnt
  );

  modport slave (
    output fifo_rempty, fifo_rdata, out_ready, flush,
    input  fifo_rinc, out_valid, out_data, flush_busy, out_cnt
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Circular skid buffer: push at tail, pop at head, synchronous clear.
// The head entry is always presented so the stream sees data with no extra cycle.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    head;
  logic [IW-1:0]    tail;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side drain controller: pops the async FIFO under credit, absorbs its
// read latency through an in-flight pipeline, and re-presents words as a stream.
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_read_ctrl_if.master  bus
);

  localparam int CW = cnt_width(BUF_DEPTH);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("fifo_read_ctrl: RD_LAT must be in 1..4");
  end
  if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("fifo_read_ctrl: BUF_DEPTH must be at least RD_LAT+1");
  end

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [RD_LAT-1:0] inflight;
  logic [RD_LAT-1:0] inflight_nxt;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  head_data;
  logic              rinc;
  logic              hs;
  logic              capture;
  logic              clear;
  int                outstanding;

  // Credit counts buffered plus in-flight words, minus the word leaving this cycle.
  always_comb begin
    outstanding  = int'(count) + $countones(inflight) - (hs ? 1 : 0);
    rinc         = !rst && (state == RUN) && !bus.fifo_rempty && (outstanding < BUF_DEPTH);
    inflight_nxt = (inflight << 1) | RD_LAT'(rinc);
  end

  assign bus.out_valid  = (count != '0) && (state == RUN);
  assign bus.out_data   = head_data;
  assign bus.fifo_rinc  = rinc;
  assign bus.flush_busy = (state == FLUSH);

  assign hs      = bus.out_valid && bus.out_ready;
  assign capture = inflight[RD_LAT-1] && (state == RUN);
  assign clear   = (state == RUN) && bus.flush;

  // Leave FLUSH once the word exiting now is the last one in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (bus.flush) state_nxt = FLUSH;
      FLUSH:   if (inflight_nxt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      inflight    <= '0;
      bus.out_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (hs) bus.out_cnt <= bus.out_cnt + 1'b1;
    end
  end

  rd_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (capture),
    .push_data (bus.fifo_rdata),
    .pop       (hs),
    .head_data (head_data),
    .count     (count)
  );

endmodule
